jacobi_1d_tstep_ctrl: RTL

JACOBI_1D_TSTEP_CTRL -- requirements
Module: jacobi_1d_tstep_ctrl

---
 rtl/jacobi_1d_tstep_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/jacobi_1d_tstep_ctrl.sv
// jacobi_1d_tstep_ctrl
// Runs a 1-D Jacobi stencil for a host-supplied number of time steps by
// calling the jacobi_1d component twice per step, swapping the ping-pong
// buffers on every call. Supports early abort and host back-pressure on done.
//
// Ports
//   clock, reset            sole clock, synchronous active-high reset
//   start / busy            host call handshake (accepted when busy=0)
//   done / stall            host return handshake (consumed when stall=0)
//   abort                   stop after the current component call
//   buf_a, buf_b, tsteps    run arguments, latched on accepted start
//   comp_start / comp_busy  call handshake towards jacobi_1d
//   comp_done / comp_stall  return handshake from jacobi_1d
//   comp_A_1/_2, comp_B     registered component arguments (src, src, dst)
//   calls_done              completed component calls in current/last run
//   aborted                 last run ended via abort (valid while done=1)
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for host start
// S_ISSUE  | comp_start held with stable arguments until accepted
// S_WAIT   | call outstanding, waiting for comp_done
// S_FINISH | done presented to host until stall=0
module jacobi_1d_tstep_ctrl #(
   parameter int CNT_W  = 16,
   parameter int ADDR_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic              stall,
   input  logic              abort,
   input  logic [ADDR_W-1:0] buf_a,
   input  logic [ADDR_W-1:0] buf_b,
   input  logic [CNT_W-1:0]  tsteps,
   output logic              comp_start,
   input  logic              comp_busy,
   input  logic              comp_done,
   output logic              comp_stall,
   output logic [ADDR_W-1:0] comp_A_1,
   output logic [ADDR_W-1:0] comp_A_2,
   output logic [ADDR_W-1:0] comp_B,
   output logic [CNT_W:0]    calls_done,
   output logic              aborted
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_FINISH
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   buf_a_q;
   logic [ADDR_W-1:0]   buf_b_q;
   logic [CNT_W:0]      total_q;
   logic [CNT_W:0]      total_in;
   logic [CNT_W:0]      calls_inc;
   logic                abort_flag;
   logic                load_args;
   logic [ADDR_W-1:0]   nxt_src;
   logic [ADDR_W-1:0]   nxt_dst;

   // Two calls per time step; the extra bit keeps 2*(2^CNT_W-1) exact.
   assign total_in  = {tsteps, 1'b0};
   assign calls_inc = calls_done + (CNT_W+1)'(1);

   assign busy       = (state != S_IDLE);
   assign done       = (state == S_FINISH);
   assign comp_start = (state == S_ISSUE);
   assign comp_stall = (state != S_WAIT);
   assign aborted    = abort_flag;

   // Arguments for the next call are computed here and registered on entry
   // to ISSUE, so the component arguments never follow inputs combinationally.
   always_comb begin
      state_nxt = state;
      load_args = 1'b0;
      nxt_src   = buf_a_q;
      nxt_dst   = buf_b_q;
      case (state)
         S_IDLE: begin
            nxt_src = buf_a;
            nxt_dst = buf_b;
            if (start) begin
               if (total_in != '0) begin
                  state_nxt = S_ISSUE;
                  load_args = 1'b1;
               end else begin
                  state_nxt = S_FINISH;
               end
            end
         end
         S_ISSUE: begin
            // An accepted call must be waited for even if abort arrives with it.
            if (!comp_busy) begin
               state_nxt = S_WAIT;
            end else if (abort) begin
               state_nxt = S_FINISH;
            end
         end
         S_WAIT: begin
            if (comp_done) begin
               if ((calls_inc == total_q) || abort_flag || abort) begin
                  state_nxt = S_FINISH;
               end else begin
                  state_nxt = S_ISSUE;
                  load_args = 1'b1;
                  if (calls_inc[0]) begin
                     nxt_src = buf_b_q;
                     nxt_dst = buf_a_q;
                  end
               end
            end
         end
         S_FINISH: begin
            if (!stall) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         buf_a_q    <= '0;
         buf_b_q    <= '0;
         total_q    <= '0;
         calls_done <= '0;
         abort_flag <= 1'b0;
         comp_A_1   <= '0;
         comp_A_2   <= '0;
         comp_B     <= '0;
      end else begin
         state <= state_nxt;
         if ((state == S_IDLE) && start) begin
            buf_a_q    <= buf_a;
            buf_b_q    <= buf_b;
            total_q    <= total_in;
            calls_done <= '0;
            abort_flag <= 1'b0;
         end
         if (((state == S_ISSUE) || (state == S_WAIT)) && abort) begin
            abort_flag <= 1'b1;
         end
         if ((state == S_WAIT) && comp_done) begin
            calls_done <= calls_inc;
         end
         if (load_args) begin
            comp_A_1 <= nxt_src;
            comp_A_2 <= nxt_src;
            comp_B   <= nxt_dst;
         end
      end
   end

endmodule
